// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl - multicycle MULT/MULTU/DIV/DIVU sequencer and HI/LO owner.
//
// Sits in EX beside the ALU. Accepts one operation at a time, runs STEPS
// shift-add (multiply) or restoring-divide iterations on operand magnitudes,
// then applies sign correction in a single FIX cycle that writes HI/LO.
// Also services MTHI/MTLO writes and raises a stall while HI/LO cannot be
// read or written because an operation is still in flight.
//
// Optional build macro: MULDIV_EARLY_OUT_EN
//   When defined, MULTU with a multiplier of 0 or 1, and any divide by zero,
//   skip RUN and go straight to FIX (result one edge after start is sampled).
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   begin the operation selected by op
//   op[1:0]     in   00 MULTU, 01 DIVU, 10 MULT, 11 DIV
//   src_a       in   multiplicand / dividend (rs)
//   src_b       in   multiplier / divisor (rt)
//   hilo_rd     in   EX stage holds MFHI or MFLO
//   hilo_we     in   bit1 MTHI, bit0 MTLO
//   hilo_wdata  in   data for MTHI/MTLO
//   busy        out  operation in progress (RUN or FIX)
//   done        out  one-cycle pulse after HI/LO were written by an operation
//   stall       out  freeze IF/ID/EX
//   hi, lo      out  HI and LO registers
//   dbg_state   out  current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: start is a single-cycle request sampled on a clk edge; it is
// accepted only when the FSM is in IDLE or FIX (FIX allows back-to-back
// issue) and silently dropped while in RUN. There is no ready/ack signal;
// the issuing pipeline uses busy/stall to learn when HI/LO are usable.
//
// STEPS must equal WIDTH: one quotient/product bit is produced per step.

module muldiv_ctrl #(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hilo_rd,
  input  logic [1:0]       hilo_we,
  input  logic [WIDTH-1:0] hilo_wdata,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // acc_hi/acc_lo: multiply = {partial product, remaining multiplier bits};
  // divide = {partial remainder, dividend bits shifting out / quotient in}.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  // opnd: multiplicand magnitude for multiply, divisor magnitude for divide.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // Operand preparation at start.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             accept;

  assign a_neg  = op[1] & src_a[WIDTH-1];
  assign b_neg  = op[1] & src_b[WIDTH-1];
  assign a_mag  = a_neg ? -src_a : src_a;
  assign b_mag  = b_neg ? -src_b : src_b;
  assign accept = start & (state_q != S_RUN);

  // One iteration of each algorithm.
  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;
  logic           div_ge;

  assign mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = (div_shift >= {1'b0, opnd_q});

  // Sign correction applied in FIX. |-2^WIDTH-1| / 1 naturally yields the
  // 0x80..0 quotient after negation, so the overflow case needs no special path.
  logic [2*WIDTH-1:0] prod_raw, prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  assign prod_raw = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_res_q ? -prod_raw : prod_raw;
  assign quot_fix = neg_res_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opnd_d    = opnd_q;
    a_raw_d   = a_raw_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = (state_q == S_FIX);

    case (state_q)
      S_IDLE: begin
        // MTHI/MTLO only land while nothing is in flight.
        if (hilo_we[1]) hi_d = hilo_wdata;
        if (hilo_we[0]) lo_d = hilo_wdata;
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
        end else begin
          acc_hi_d = mul_sum[WIDTH:1];
          acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(STEPS - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (div0_q) begin
          lo_d = '1;
          hi_d = a_raw_q;
        end else if (is_div_q) begin
          lo_d = quot_fix;
          hi_d = rem_fix;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A start in IDLE or FIX latches operands; the FIX-cycle HI/LO write
    // above still completes on the same edge.
    if (accept) begin
      is_div_d  = op[0];
      neg_res_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      a_raw_d   = src_a;
      div0_d    = op[0] & (src_b == '0);
      acc_hi_d  = '0;
      acc_lo_d  = op[0] ? a_mag : b_mag;
      opnd_d    = op[0] ? b_mag : a_mag;
      cnt_d     = '0;
      state_d   = S_RUN;
`ifdef MULDIV_EARLY_OUT_EN
      // Trivial MULTU: product is 0 or a, preloaded so FIX sees it directly.
      if (op == 2'b00 && b_mag[WIDTH-1:1] == '0) begin
        acc_lo_d = b_mag[0] ? a_mag : '0;
        state_d  = S_FIX;
      end
      if (op[0] && src_b == '0) state_d = S_FIX;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opnd_q    <= '0;
      a_raw_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opnd_q    <= opnd_d;
      a_raw_q   <= a_raw_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign stall     = busy & (hilo_rd | (hilo_we != 2'b00));
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl - directed self-checking bench for muldiv_ctrl.
// Inputs are driven just after the falling edge; outputs are sampled on the
// falling edge (or 1 ns after a combinational input change).

module tb_muldiv_ctrl;

  localparam int W = 32;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] src_a, src_b;
  logic         hilo_rd;
  logic [1:0]   hilo_we;
  logic [W-1:0] hilo_wdata;
  logic         busy, done, stall;
  logic [W-1:0] hi, lo;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  muldiv_ctrl #(.WIDTH(W), .STEPS(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .hilo_rd(hilo_rd), .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .busy(busy), .done(done), .stall(stall),
    .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // ---------------- drivers ----------------
  // Returns at the falling edge just after E0; operands are then scrambled
  // so any late sampling by the DUT shows up as a wrong result.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = ~o; src_a = ~a; src_b = ~b;
  endtask

  // Counts falling edges until done is seen, bounded at 80.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 80);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    hilo_rd = 1'b0; hilo_we = 2'b00; hilo_wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL reset_hilo got %h/%h want 0/0", hi, lo); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
    rst = 1'b0;
  endtask

  task automatic test_multu();
    int bad_busy = 0;
    int bad_done = 0;
    start_op(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    for (int k = 1; k <= 33; k++) begin
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) bad_done++;
      @(negedge clk);
    end
    checks++; if (bad_busy != 0) begin errors++; $display("FAIL multu_busy_window got %0d low cycles want 0", bad_busy); end
    checks++; if (bad_done != 0) begin errors++; $display("FAIL multu_early_done got %0d cycles want 0", bad_done); end
    checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL multu_done_e33 got done=%b busy=%b want 1/0", done, busy); end
    checks++; if (hi !== 32'h0000_0001) begin errors++; $display("FAIL multu_hi got %h want 00000001", hi); end
    checks++; if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo got %h want fffffffe", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse got %b want 0", done); end
  endtask

  task automatic test_signed();
    int n;
    start_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0003);
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL mult_latency got %0d want 33", n); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_neg got %h_%h want ffffffff_ffffffeb", hi, lo); end
    start_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL div_latency got %0d want 33", n); end
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg got q=%h r=%h want fffffffd/ffffffff", lo, hi); end
    start_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin errors++; $display("FAIL div_ovf got q=%h r=%h want 80000000/0", lo, hi); end
    start_op(2'b11, 32'h0000_0011, 32'hFFFF_FFFB);  // 17 / -5 = -3 r 2
    wait_done(n);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'h0000_0002) begin errors++; $display("FAIL div_negdivisor got q=%h r=%h want fffffffd/2", lo, hi); end
  endtask

  task automatic test_div_zero();
    int n;
    start_op(2'b01, 32'd100, 32'd0);
    wait_done(n);
    checks++; if (n != EARLY_LAT) begin errors++; $display("FAIL divu0_latency got %0d want %0d", n, EARLY_LAT); end
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd100) begin errors++; $display("FAIL divu0_result got q=%h r=%h want ffffffff/64", lo, hi); end
    start_op(2'b11, 32'hFFFF_FFFB, 32'd0);
    wait_done(n);
    checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL div0_signed got q=%h r=%h want ffffffff/fffffffb", lo, hi); end
    start_op(2'b00, 32'h0000_1234, 32'd1);
    wait_done(n);
    checks++; if (n != EARLY_LAT) begin errors++; $display("FAIL multu1_latency got %0d want %0d", n, EARLY_LAT); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0000_1234) begin errors++; $display("FAIL multu1_result got %h_%h want 0_00001234", hi, lo); end
  endtask

  task automatic test_stall_ignore();
    int bad = 0;
    start_op(2'b01, 32'd50, 32'd7);
    @(negedge clk);                         // after E1
    hilo_rd = 1'b1;
    #1;
    for (int k = 2; k <= 33; k++) begin
      if (stall !== 1'b1) bad++;
      if (k == 10) begin start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd3; end
      if (k == 11) start = 1'b0;
      @(negedge clk);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_window got %0d low cycles want 0", bad); end
    checks++; if (stall !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL stall_release got stall=%b done=%b want 0/1", stall, done); end
    checks++; if (hi !== 32'd1 || lo !== 32'd7) begin errors++; $display("FAIL divu_50_7 got q=%h r=%h want 7/1", lo, hi); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || hi !== 32'd1 || lo !== 32'd7) begin errors++; $display("FAIL ignored_start got busy=%b hi=%h lo=%h want 0/1/7", busy, hi, lo); end
    hilo_rd = 1'b0;
  endtask

  task automatic test_mthi_mtlo();
    int n;
    @(negedge clk);
    hilo_we = 2'b10; hilo_wdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mthi_idle_stall got %b want 0", stall); end
    @(negedge clk);
    hilo_we = 2'b00;
    checks++; if (hi !== 32'hDEAD_BEEF || lo !== 32'd7) begin errors++; $display("FAIL mthi_write got %h/%h want deadbeef/7", hi, lo); end
    start_op(2'b00, 32'd2, 32'd3);
    hilo_we = 2'b01; hilo_wdata = 32'h1234_5678;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mtlo_run_stall got %b want 1", stall); end
    repeat (5) @(negedge clk);
    checks++; if (lo !== 32'd7) begin errors++; $display("FAIL mtlo_run_blocked got %h want 7", lo); end
    wait_done(n);
    checks++; if (lo !== 32'd6 || hi !== 32'd0 || stall !== 1'b0) begin errors++; $display("FAIL mtlo_after_op got %h/%h stall=%b want 0/6/0", hi, lo, stall); end
    @(negedge clk);
    hilo_we = 2'b00;
    checks++; if (lo !== 32'h1234_5678 || hi !== 32'd0) begin errors++; $display("FAIL mtlo_applied got %h/%h want 0/12345678", hi, lo); end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    hilo_we = 2'b10; hilo_wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    hilo_we = 2'b00;
    start_op(2'b00, 32'hFFFF_FFFF, 32'h2);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL midrst_hilo got %h/%h want 0/0", hi, lo); end
    @(negedge clk);
    rst = 1'b0;
    start_op(2'b00, 32'd5, 32'd7);
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL postrst_latency got %0d want 33", n); end
    checks++; if (hi !== 32'd0 || lo !== 32'd35) begin errors++; $display("FAIL postrst_result got %h/%h want 0/23", hi, lo); end
  endtask

  task automatic test_back_to_back();
    int n;
    start_op(2'b10, 32'hFFFF_FFF9, 32'h3);
    repeat (32) @(negedge clk);             // after E32, FIX
    start = 1'b1; op = 2'b01; src_a = 32'd1000; src_b = 32'd3;
    @(negedge clk);                         // after E33
    start = 1'b0; src_a = '0; src_b = '0;
    checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got done=%b busy=%b want 1/1", done, busy); end
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL b2b_first got %h_%h want ffffffff_ffffffeb", hi, lo); end
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", n); end
    checks++; if (lo !== 32'd333 || hi !== 32'd1) begin errors++; $display("FAIL b2b_second got q=%h r=%h want 14d/1", lo, hi); end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_zero();
    test_stall_ignore();
    test_mthi_mtlo();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Multicycle sequencer for MIPS MULT/MULTU/DIV/DIVU and the HI/LO register pair, in the EX stage beside the ALU.
- Accepts one operation at a time and iterates 32 shift-add or restoring-divide steps.
- Owns HI/LO and services MFHI/MFLO/MTHI/MTLO.
- Produces a stall to the hazard logic while a result or HI/LO access cannot be honoured.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- STEPS, 32, iteration count per operation; must equal WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to begin the operation in op; sampled on a clk edge.
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV.
- src_a  in  WIDTH  multiplicand / dividend (rs).
- src_b  in  WIDTH  multiplier / divisor (rt).
- hilo_rd  in  1  EX stage holds MFHI or MFLO.
- hilo_we  in  2  bit1 MTHI, bit0 MTLO.
- hilo_wdata  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse: HI/LO updated this edge.
- stall  out  1  freeze IF/ID/EX.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (async, any time incl. mid-operation): state IDLE; busy=0, done=0, stall=0, hi=0, lo=0; iteration counter=0; partial results discarded.
- States: IDLE -> RUN on start. RUN -> FIX after STEPS iterations. FIX -> IDLE in 1 cycle, writing HI/LO and pulsing done.
- busy=1 in RUN and FIX.
- start while busy=1 is ignored; no queueing.
- Latency:
  - start sampled at edge E0.
  - RUN spans edges E1..E32.
  - FIX writes hi/lo at E33; done=1 in the cycle after E33.
  - Next start accepted at E33 at the earliest (back-to-back).
- Operands and op latched at E0; later changes on src_a/src_b/op have no effect.
- MULTU: 64-bit unsigned product; hi=[63:32], lo=[31:0].
- DIVU: restoring division; lo=quotient, hi=remainder.
- Signed ops: operands converted to magnitudes at E0.
  - Product negated (two's complement, 64-bit) if signs differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - -2^31 / -1: lo=32'h8000_0000, hi=0.
- Divide by zero (any op): lo=32'hFFFF_FFFF, hi=src_a as latched; full latency retained.
- stall = busy & (hilo_rd | (hilo_we != 0)); combinational.
- start alone never stalls; the pipeline proceeds past MULT/DIV.
- hilo_we when busy=0: selected register(s) written at that edge.
- hilo_we and start in the same IDLE edge: the write applies, the operation starts, and its result later overwrites both HI and LO.
- hilo_rd returns current hi/lo when stall=0.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: an unsigned multiply whose latched multiplier magnitude is 0 or 1 skips RUN, going IDLE -> FIX directly; done follows start by 2 cycles (result at E1).
  - Divide by zero also skips RUN, with the same results as above.
- Undefined: every operation takes the full STEPS iterations (result at E33); no extra comparators are synthesised.

Test Plan:
- MULTU a=32'hFFFF_FFFF, b=32'h0000_0002 -> at E33 hi=32'h0000_0001, lo=32'hFFFF_FFFE; done pulses once; busy high E1..E33.
- MULT a=-7 (32'hFFFF_FFF9), b=3 -> hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB. Then DIV a=-7, b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
- DIVU a=100, b=0 -> lo=32'hFFFF_FFFF, hi=100 (E33 without the macro, E1 with it). DIV a=32'h8000_0000, b=-1 -> lo=32'h8000_0000, hi=0.
- Start DIVU 50/7; hold hilo_rd=1 from E2 -> stall=1 until FIX completes, then hi=1, lo=7 readable with stall=0; a second start at E10 is ignored.
- MTHI 32'hDEAD_BEEF in IDLE -> hi updated next edge with no stall. MTLO during RUN -> stall=1 and lo unchanged until IDLE.
- Assert rst at E15 of a MULTU -> busy, done, hi, lo = 0 immediately. A new start after reset release completes normally in 33 cycles.
